// File: rtl/alu_seq_if.sv
// ---------------------------------------------------------------------------
// alu_seq_if : operand/result bundle between the controller and alu_seq.
//   master (controller) drives start, ALUop, Ain, Bin
//   slave  (alu_seq)    drives out, N, V, Z, busy, done
// ---------------------------------------------------------------------------
interface alu_seq_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [2:0]       ALUop;
   logic [WIDTH-1:0] Ain;
   logic [WIDTH-1:0] Bin;
   logic [WIDTH-1:0] out;
   logic             N;
   logic             V;
   logic             Z;
   logic             busy;
   logic             done;

   modport master (
      output start, ALUop, Ain, Bin,
      input  out, N, V, Z, busy, done
   );

   modport slave (
      input  start, ALUop, Ain, Bin,
      output out, N, V, Z, busy, done
   );
endinterface

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq : clocked ALU with N/V/Z flags and a start/busy/done handshake.
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    alu_seq_if slave port:
//            start       request, sampled when busy=0
//            ALUop[2:0]  000 add, 001 sub, 010 and, 011 not B, 100 or,
//                        101 xor, 110 multiply (WIDTH cycles), 111 asr
//            Ain, Bin    operands
//            out, N,V,Z  registered result and flags, updated with done
//            busy        high while a multiply is in progress
//            done        one-cycle completion pulse
// ---------------------------------------------------------------------------
module alu_seq #(
   parameter int WIDTH = 16
) (
   input logic       clk,
   input logic       reset,
   alu_seq_if.slave  bus
);
   localparam int SHW = $clog2(WIDTH);
   localparam int CW  = $clog2(WIDTH + 1);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_NOT = 3'b011;
   localparam logic [2:0] OP_OR  = 3'b100;
   localparam logic [2:0] OP_XOR = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;
   localparam logic [2:0] OP_ASR = 3'b111;

   typedef enum logic {
      S_IDLE,
      S_MUL
   } state_t;

   state_t             state_q;
   logic [WIDTH-1:0]   out_q;
   logic               n_q, v_q, z_q;
   logic               busy_q, done_q;
   logic [2*WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [CW-1:0]      cnt_q;

   // single-cycle result path
   logic [WIDTH-1:0]   res_d;
   logic               v_d;
   logic [SHW-1:0]     shamt;
   logic               a_msb, b_msb;

   // multiply step path
   logic [2*WIDTH-1:0] acc_d;

   always_comb begin
      res_d = '0;
      v_d   = 1'b0;
      shamt = bus.Bin[SHW-1:0];
      a_msb = bus.Ain[WIDTH-1];
      b_msb = bus.Bin[WIDTH-1];
      unique case (bus.ALUop)
         OP_ADD: begin
            res_d = bus.Ain + bus.Bin;
            v_d   = (a_msb == b_msb) && (res_d[WIDTH-1] != a_msb);
         end
         OP_SUB: begin
            res_d = bus.Ain - bus.Bin;
            v_d   = (a_msb != b_msb) && (res_d[WIDTH-1] != a_msb);
         end
         OP_AND: res_d = bus.Ain & bus.Bin;
         OP_NOT: res_d = ~bus.Bin;
         OP_OR:  res_d = bus.Ain | bus.Bin;
         OP_XOR: res_d = bus.Ain ^ bus.Bin;
         OP_ASR: res_d = $signed(bus.Ain) >>> shamt;
         default: res_d = '0;  // OP_MUL handled by the sequencer
      endcase
   end

   always_comb begin
      acc_d = acc_q;
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         out_q    <= '0;
         n_q      <= 1'b0;
         v_q      <= 1'b0;
         z_q      <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  if (bus.ALUop == OP_MUL) begin
                     mcand_q  <= {{WIDTH{1'b0}}, bus.Ain};
                     mplier_q <= bus.Bin;
                     acc_q    <= '0;
                     cnt_q    <= CW'(WIDTH);
                     busy_q   <= 1'b1;
                     state_q  <= S_MUL;
                  end else begin
                     out_q  <= res_d;
                     n_q    <= res_d[WIDTH-1];
                     v_q    <= v_d;
                     z_q    <= (res_d == '0);
                     done_q <= 1'b1;
                  end
               end
            end
            S_MUL: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q - 1'b1;
               // last step: publish the freshly accumulated product directly
               if (cnt_q == CW'(1)) begin
                  out_q   <= acc_d[WIDTH-1:0];
                  n_q     <= acc_d[WIDTH-1];
                  v_q     <= |acc_d[2*WIDTH-1:WIDTH];
                  z_q     <= (acc_d[WIDTH-1:0] == '0);
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.out  = out_q;
   assign bus.N    = n_q;
   assign bus.V    = v_q;
   assign bus.Z    = z_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, clocked successor to the datapath ALU.
- Adds four operations (OR, XOR, multi-cycle multiply, arithmetic shift right), N/V/Z status flags and a start/busy/done handshake.
- Sits between the register-file operand latches and the writeback mux.
- The controller FSM issues one operation per start pulse and waits for done before writeback.

Parameters:
- WIDTH, 16, operand/result width in bits (>= 4).
- SHW (localparam), $clog2(WIDTH), width of the shift-amount field taken from Bin.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; operands and op are sampled on the clk edge where start=1 and busy=0.
- ALUop  input  3  operation select.
- Ain  input  WIDTH  operand A.
- Bin  input  WIDTH  operand B.
- out  output  WIDTH  registered result; holds until the next completion.
- N  output  1  registered: out[WIDTH-1].
- V  output  1  registered overflow flag.
- Z  output  1  registered: out==0.
- busy  output  1  high while a multiply is in progress.
- done  output  1  one-cycle pulse; out/N/V/Z are updated in the same cycle.

Behaviour:
- Reset (synchronous, active-high; clk edge with reset=1): out=0, N=0, V=0, Z=1, busy=0, done=0, state=IDLE.
  - Reset overrides start and aborts any in-flight multiply; no done is produced for an aborted operation.
- Ops (A, B = values sampled at start):
  - 000 A+B.
  - 001 A-B.
  - 010 A&B.
  - 011 ~B.
  - 100 A|B.
  - 101 A^B.
  - 110 A*B unsigned, low WIDTH bits.
  - 111 arithmetic shift right of A by B[SHW-1:0].
- Arithmetic is modulo 2^WIDTH.
- V flag:
  - ADD: signed overflow (operand signs equal, result sign differs).
  - SUB: signed overflow (operand signs differ, result sign differs from A).
  - MUL: 1 when the upper WIDTH bits of the 2*WIDTH product are nonzero.
  - All other ops: V=0.
- States: IDLE, MUL.
- IDLE, start=1 with op != 110:
  - Result and flags are computed combinationally and registered on that edge (E0).
  - done=1 for the following cycle only.
  - Latency is 1 cycle; busy stays 0.
  - Back-to-back single-cycle starts on consecutive edges are legal; each produces its own done pulse.
- IDLE, start=1 with op == 110:
  - At E0: latch A into a multiplicand shift register, B into a multiplier shift register, clear the 2*WIDTH accumulator, counter=WIDTH, busy=1, go to MUL.
- MUL:
  - Each edge: if multiplier LSB=1, add the shifted multiplicand to the accumulator.
  - Shift multiplicand left and multiplier right; decrement counter.
  - On the edge where counter goes 1->0 (edge E_WIDTH):
    - Register out = acc[WIDTH-1:0] and the flags.
    - Set busy=0, done=1, return to IDLE.
  - Total: done is visible in the cycle after E_WIDTH (WIDTH cycles after E0).
- start while busy=1 is ignored (no queuing); Ain/Bin/ALUop changes during MUL have no effect.
- done is never asserted in two consecutive cycles from the same operation.
- out/N/V/Z change only on a done edge or on reset.
- ASR shift amount 0 returns A unchanged; amount WIDTH-1 yields all sign bits.

Test Plan:
- Reset: hold reset=1 for 2 edges with start=1, ALUop=000, Ain=3, Bin=11 -> out=0, Z=1, N=0, V=0, busy=0, done=0; release, no done appears.
- ADD/SUB/logic, WIDTH=16, one start per cycle on consecutive edges:
  - 3+11 -> out=14, N=0, V=0, Z=0.
  - 0x7FFF+0x0001 -> out=0x8000, N=1, V=1.
  - 5-5 -> out=0, Z=1.
  - 0x8000-0x0001 -> out=0x7FFF, V=1.
  - 7&9 -> out=0x0001.
  - ~4 -> out=0xFFFB, N=1.
  - Each result arrives with done high exactly 1 cycle after its start edge.
- MUL 300*7:
  - -> out=0x0834, V=0.
  - busy=1 for 16 cycles after the start edge; done pulses once, 16 cycles after start.
  - A start pulse with ALUop=000 at cycle 5 is ignored; out is unchanged until done.
- MUL 0x0100*0x0100 -> out=0x0000, Z=1, V=1. MUL 0xFFFF*0x0001 -> out=0xFFFF, N=1, V=0.
- Reset mid-operation: start MUL 300*7, assert reset at cycle 8 for one edge -> busy=0, out=0, Z=1, no done. A following ADD 2+2 gives out=4 with done 1 cycle later.
- ASR/OR/XOR:
  - ASR 0x8000 by 4 -> 0xF800, N=1.
  - ASR 0x4000 by 15 -> 0x0000, Z=1.
  - ASR 0x1234 by 0 -> 0x1234.
  - 0x00F0|0x0F00 -> 0x0FF0.
  - 0xFFFF^0xFFFF -> 0x0000, Z=1.
